// File: rtl/gate_truth_checker.sv
// Clocked truth-table sweeper for a combinational gate: drives every input vector,
// waits SETTLE cycles, samples the gate output and tallies mismatches against EXPECT.
module gate_truth_checker #(
    parameter int unsigned          N_IN   = 2,
    parameter int unsigned          SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic              fv_q, fv_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffv_d   = '0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            S_CHECK: begin
                // Case-inequality so an X/Z gate output is scored as a mismatch.
                if (dut_out !== EXPECT[vec_q]) begin
                    err_d = err_q + (N_IN + 1)'(1);
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffv_d = vec_q;
                    end
                end
                if (vec_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_in         = vec_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized truth-table sweeps against a popcount/lowest-set-bit reference model,
// on a default 2-input instance and a 3-input, SETTLE=1 instance.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] din_a;
    logic [2:0] din_b;
    logic       out_a, out_b;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [2:0] err_a;
    logic [3:0] err_b;
    logic [1:0] ffv_a;
    logic [2:0] ffv_b;

    // Behaviour of the gate under test: output for input k is tbl[k].
    logic [3:0] tbl_a = 4'b1000;
    logic [7:0] tbl_b = 8'h80;
    always_comb out_a = tbl_a[din_a];
    always_comb out_b = tbl_b[din_b];

    gate_truth_checker u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(din_a), .dut_out(out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .first_fail_vec(ffv_a)
    );

    gate_truth_checker #(.N_IN(3), .SETTLE(1), .EXPECT(8'h80)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(din_b), .dut_out(out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .first_fail_vec(ffv_b)
    );

    int sel = 0;
    logic       m_busy, m_done, m_pass, m_fv;
    logic [4:0] m_err;
    logic [3:0] m_ffv, m_din;
    always_comb begin
        m_busy = busy_a; m_done = done_a; m_pass = pass_a; m_fv = fv_a;
        m_err = 5'(err_a); m_ffv = 4'(ffv_a); m_din = 4'(din_a);
        if (sel != 0) begin
            m_busy = busy_b; m_done = done_b; m_pass = pass_b; m_fv = fv_b;
            m_err = 5'(err_b); m_ffv = 4'(ffv_b); m_din = 4'(din_b);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    // One full sweep; tbl is the gate behaviour, poke re-asserts start mid-sweep.
    task automatic run_sweep(input int which, input logic [7:0] tbl, input bit poke);
        int          nvec, settle, cyc, exp_err, first;
        logic [7:0]  exp_tt;
        sel    = which;
        nvec   = (which == 0) ? 4 : 8;
        settle = (which == 0) ? 2 : 1;
        exp_tt = (which == 0) ? 8'h08 : 8'h80;
        if (which == 0) tbl_a = tbl[3:0]; else tbl_b = tbl;
        exp_err = 0;
        first   = 0;
        for (int k = 0; k < nvec; k++) begin
            if (tbl[k] != exp_tt[k]) begin
                if (exp_err == 0) first = k;
                exp_err++;
            end
        end
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("busy_after_accept", 32'(m_busy), 1);
        check("err_cleared", 32'(m_err), 0);
        check("fv_cleared", 32'(m_fv), 0);
        check("pass_cleared", 32'(m_pass), 0);
        cyc = 1;
        while (!m_done && cyc < 64) begin
            check("dut_in_step", 32'(m_din), 32'((cyc - 1) / (settle + 1)));
            if (poke && cyc == 4) set_start(1'b1);
            if (poke && cyc == 5) set_start(1'b0);
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", 32'(cyc), 32'(nvec * (settle + 1) + 1));
        check("busy_in_done", 32'(m_busy), 1);
        @(negedge clk);
        check("done_pulse_end", 32'(m_done), 0);
        check("busy_end", 32'(m_busy), 0);
        check("pass", 32'(m_pass), 32'(exp_err == 0));
        check("err_count", 32'(m_err), 32'(exp_err));
        check("fail_valid", 32'(m_fv), 32'(exp_err != 0));
        check("first_fail_vec", 32'(m_ffv), 32'(first));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dut_in"}, 32'(din_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_pass"}, 32'(pass_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_fv"}, 32'(fv_a), 0);
        check({tag, "_ffv"}, 32'(ffv_a), 0);
        check({tag, "_b_busy"}, 32'(busy_b), 0);
    endtask

    initial begin
        logic [7:0] r;
        int cyc;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        run_sweep(0, 8'h08, 1'b0);
        run_sweep(0, 8'h00, 1'b0);
        run_sweep(0, 8'h0f, 1'b0);
        run_sweep(0, 8'h08, 1'b1);
        run_sweep(0, 8'h0f, 1'b1);

        // Asynchronous reset while vector 2 is settling, with errors already counted.
        sel = 0;
        tbl_a = 4'b1111;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (din_a != 2'd2 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_vec2", 32'(din_a), 2);
        check("err_before_rst", 32'(err_a), 2);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 8'h08, 1'b0);

        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            run_sweep(0, r, 1'($urandom_range(0, 1)));
        end

        run_sweep(1, 8'h80, 1'b0);
        run_sweep(1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            run_sweep(1, r, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
